// File: rtl/f1_pkg.sv
// rtl/f1_pkg.sv - shared types and widths for the F1 start-light sequencer
package f1_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LIGHTS = 2'd1,
    HOLD   = 2'd2,
    REACT  = 2'd3
  } state_t;

  localparam int LFSR_W  = 4;
  localparam int DELAY_W = 5;

endpackage

// File: rtl/rise_detect.sv
// rtl/rise_detect.sv - 1-bit rising-edge detector, history flop resets high
module rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic d_q;
  logic d_d;

  always_comb begin
    d_d = d;
  end

  // Resetting high means a level already asserted at reset release is not an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) d_q <= 1'b1;
    else     d_q <= d_d;
  end

  assign rise = d & ~d_q;

endmodule

// File: rtl/f1_start_ctrl.sv
// rtl/f1_start_ctrl.sv - F1 start-light sequencer with random hold and reaction timer
module f1_start_ctrl
  import f1_pkg::*;
#(
  parameter int N_LIGHTS  = 8,
  parameter int DELAY_MIN = 1,
  parameter int RT_WIDTH  = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                tick,
  input  logic                trigger,
  input  logic                react,
  input  logic [LFSR_W-1:0]   lfsr_data,
  output logic                lfsr_en,
  output logic [N_LIGHTS-1:0] lights,
  output logic                busy,
  output logic                done,
  output logic                jump_start,
  output logic                rt_valid,
  output logic [RT_WIDTH-1:0] reaction_time
);

  localparam int CNT_W = $clog2(N_LIGHTS + 1);

  logic trig_e;
  logic react_e;

  rise_detect u_trig_rise (
    .clk  (clk),
    .rst  (rst),
    .d    (trigger),
    .rise (trig_e)
  );

  rise_detect u_react_rise (
    .clk  (clk),
    .rst  (rst),
    .d    (react),
    .rise (react_e)
  );

  state_t              state_q, state_d;
  logic [N_LIGHTS-1:0] lights_q, lights_d;
  logic [CNT_W-1:0]    light_cnt_q, light_cnt_d;
  logic [DELAY_W-1:0]  delay_cnt_q, delay_cnt_d;
  logic [RT_WIDTH-1:0] rt_cnt_q, rt_cnt_d;
  logic [RT_WIDTH-1:0] reaction_time_q, reaction_time_d;
  logic                rt_valid_q, rt_valid_d;
  logic                jump_start_q, jump_start_d;
  logic                done_q, done_d;

  always_comb begin
    state_d         = state_q;
    lights_d        = lights_q;
    light_cnt_d     = light_cnt_q;
    delay_cnt_d     = delay_cnt_q;
    rt_cnt_d        = rt_cnt_q;
    reaction_time_d = reaction_time_q;
    rt_valid_d      = rt_valid_q;
    jump_start_d    = jump_start_q;
    done_d          = 1'b0;

    // A press before lamps-out wins over any tick arriving in the same cycle.
    if (react_e && (state_q == LIGHTS || state_q == HOLD)) begin
      lights_d     = '0;
      jump_start_d = 1'b1;
      done_d       = 1'b1;
      state_d      = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (trig_e) begin
            state_d         = LIGHTS;
            light_cnt_d     = '0;
            jump_start_d    = 1'b0;
            rt_valid_d      = 1'b0;
            reaction_time_d = '0;
          end
        end
        LIGHTS: begin
          if (tick) begin
            lights_d    = {lights_q[N_LIGHTS-2:0], 1'b1};
            light_cnt_d = light_cnt_q + CNT_W'(1);
            if (&lights_d) begin
              state_d     = HOLD;
              delay_cnt_d = DELAY_W'(lfsr_data) + DELAY_W'(DELAY_MIN);
            end
          end
        end
        HOLD: begin
          if (tick) begin
            delay_cnt_d = delay_cnt_q - DELAY_W'(1);
            if (delay_cnt_q == DELAY_W'(1)) begin
              lights_d = '0;
              rt_cnt_d = '0;
              state_d  = REACT;
            end
          end
        end
        REACT: begin
          if (tick && rt_cnt_q != '1) rt_cnt_d = rt_cnt_q + RT_WIDTH'(1);
          // Capture the pre-increment count when press and tick coincide.
          if (react_e) begin
            reaction_time_d = rt_cnt_q;
            rt_valid_d      = 1'b1;
            done_d          = 1'b1;
            state_d         = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= IDLE;
      lights_q        <= '0;
      light_cnt_q     <= '0;
      delay_cnt_q     <= '0;
      rt_cnt_q        <= '0;
      reaction_time_q <= '0;
      rt_valid_q      <= 1'b0;
      jump_start_q    <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      lights_q        <= lights_d;
      light_cnt_q     <= light_cnt_d;
      delay_cnt_q     <= delay_cnt_d;
      rt_cnt_q        <= rt_cnt_d;
      reaction_time_q <= reaction_time_d;
      rt_valid_q      <= rt_valid_d;
      jump_start_q    <= jump_start_d;
      done_q          <= done_d;
    end
  end

  // The LFSR must stop once the hold delay has been sampled.
  assign lfsr_en       = (state_q == IDLE) || (state_q == LIGHTS);
  assign busy          = (state_q != IDLE);
  assign lights        = lights_q;
  assign done          = done_q;
  assign jump_start    = jump_start_q;
  assign rt_valid      = rt_valid_q;
  assign reaction_time = reaction_time_q;

endmodule

// File: tb/tb_f1_start_ctrl.sv
// tb/tb_f1_start_ctrl.sv - directed self-checking bench for f1_start_ctrl
module tb_f1_start_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tick = 1'b0;
  logic        trigger = 1'b0;
  logic        react = 1'b0;
  logic [3:0]  lfsr_data = 4'd0;

  logic        lfsr_en, busy, done, jump_start, rt_valid;
  logic [7:0]  lights;
  logic [15:0] reaction_time;

  logic        lfsr_en4, busy4, done4, jump_start4, rt_valid4;
  logic [7:0]  lights4;
  logic [3:0]  reaction_time4;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  f1_start_ctrl #(.N_LIGHTS(8), .DELAY_MIN(1), .RT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .tick(tick), .trigger(trigger), .react(react),
    .lfsr_data(lfsr_data), .lfsr_en(lfsr_en), .lights(lights), .busy(busy),
    .done(done), .jump_start(jump_start), .rt_valid(rt_valid),
    .reaction_time(reaction_time)
  );

  f1_start_ctrl #(.N_LIGHTS(8), .DELAY_MIN(1), .RT_WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .tick(tick), .trigger(trigger), .react(react),
    .lfsr_data(lfsr_data), .lfsr_en(lfsr_en4), .lights(lights4), .busy(busy4),
    .done(done4), .jump_start(jump_start4), .rt_valid(rt_valid4),
    .reaction_time(reaction_time4)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_once();
    tick = 1'b1;
    step();
    tick = 1'b0;
    repeat (3) step();
  endtask

  task automatic start_run();
    trigger = 1'b1;
    step();
    trigger = 1'b0;
    step();
  endtask

  task automatic press();
    react = 1'b1;
    step();
    react = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    total++;
    if ({lights, busy, done, jump_start, rt_valid, reaction_time} !== 28'd0) begin
      bad++;
      $display("FAIL reset_state got lights=%0h busy=%0b done=%0b js=%0b rv=%0b rt=%0d exp all 0",
               lights, busy, done, jump_start, rt_valid, reaction_time);
    end
    repeat (2) step();
    rst = 1'b0;
    repeat (2) step();
  endtask

  task automatic test_full_run();
    logic [7:0] exp_l;
    lfsr_data = 4'd5;
    trigger = 1'b1;
    step();
    trigger = 1'b0;
    total++;
    if (busy !== 1'b1 || lights !== 8'h00) begin
      bad++; $display("FAIL run_start got busy=%0b lights=%0h exp busy=1 lights=00", busy, lights);
    end
    step();
    exp_l = 8'h00;
    for (int i = 0; i < 8; i++) begin
      tick_once();
      exp_l = {exp_l[6:0], 1'b1};
      total++;
      if (lights !== exp_l) begin
        bad++; $display("FAIL lamp_step%0d got %0h exp %0h", i, lights, exp_l);
      end
    end
    lfsr_data = 4'd9;
    for (int i = 0; i < 5; i++) tick_once();
    total++;
    if (lights !== 8'hFF || lfsr_en !== 1'b0) begin
      bad++; $display("FAIL hold5 got lights=%0h en=%0b exp FF 0", lights, lfsr_en);
    end
    tick_once();
    total++;
    if (lights !== 8'h00 || busy !== 1'b1) begin
      bad++; $display("FAIL lamps_out got lights=%0h busy=%0b exp 00 1", lights, busy);
    end
    repeat (3) tick_once();
    press();
    total++;
    if (reaction_time !== 16'd3 || rt_valid !== 1'b1 || done !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL run_end got rt=%0d rv=%0b done=%0b busy=%0b exp 3 1 1 0",
                      reaction_time, rt_valid, done, busy);
    end
    step();
    total++;
    if (done !== 1'b0) begin
      bad++; $display("FAIL done_width got %0b exp 0", done);
    end
  endtask

  task automatic test_jump_start();
    lfsr_data = 4'd5;
    start_run();
    repeat (3) tick_once();
    total++;
    if (lights !== 8'h07) begin
      bad++; $display("FAIL js_pre got %0h exp 07", lights);
    end
    press();
    total++;
    if (lights !== 8'h00 || jump_start !== 1'b1 || rt_valid !== 1'b0 || done !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL jump_start got l=%0h js=%0b rv=%0b done=%0b busy=%0b exp 00 1 0 1 0",
                      lights, jump_start, rt_valid, done, busy);
    end
    step();
    press();
    step();
    total++;
    if (jump_start !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || lights !== 8'h00) begin
      bad++; $display("FAIL idle_react got js=%0b busy=%0b done=%0b l=%0h exp 1 0 0 00",
                      jump_start, busy, done, lights);
    end
  endtask

  task automatic test_delay_bounds(input logic [3:0] lv, input int exp_ticks);
    int n;
    logic en_bad;
    lfsr_data = lv;
    start_run();
    repeat (8) tick_once();
    n = 0;
    en_bad = 1'b0;
    while (lights !== 8'h00 && n < 40) begin
      if (lfsr_en !== 1'b0) en_bad = 1'b1;
      tick_once();
      n++;
    end
    total++;
    if (n !== exp_ticks) begin
      bad++; $display("FAIL hold_ticks_l%0d got %0d exp %0d", lv, n, exp_ticks);
    end
    tick_once();
    if (lfsr_en !== 1'b0) en_bad = 1'b1;
    total++;
    if (en_bad !== 1'b0) begin
      bad++; $display("FAIL lfsr_en_frozen_l%0d got en high exp 0", lv);
    end
    press();
    total++;
    if (reaction_time !== 16'd1 || done !== 1'b1) begin
      bad++; $display("FAIL bound_rt_l%0d got rt=%0d done=%0b exp 1 1", lv, reaction_time, done);
    end
    step();
  endtask

  task automatic test_react_with_tick();
    lfsr_data = 4'd0;
    start_run();
    repeat (9) tick_once();
    repeat (4) tick_once();
    tick = 1'b1;
    react = 1'b1;
    step();
    tick = 1'b0;
    react = 1'b0;
    total++;
    if (reaction_time !== 16'd4 || reaction_time4 !== 4'd4 || done !== 1'b1) begin
      bad++; $display("FAIL react_tick got rt=%0d rt4=%0d done=%0b exp 4 4 1",
                      reaction_time, reaction_time4, done);
    end
    step();
  endtask

  task automatic test_saturation();
    lfsr_data = 4'd0;
    start_run();
    repeat (9) tick_once();
    repeat (20) tick_once();
    press();
    total++;
    if (reaction_time4 !== 4'd15 || reaction_time !== 16'd20 || rt_valid4 !== 1'b1) begin
      bad++; $display("FAIL saturate got rt4=%0d rt=%0d rv4=%0b exp 15 20 1",
                      reaction_time4, reaction_time, rt_valid4);
    end
    step();
  endtask

  task automatic test_trigger_held_and_reset();
    int done_seen;
    lfsr_data = 4'd5;
    trigger = 1'b1;
    step();
    tick_once();
    press();
    step();
    repeat (5) step();
    total++;
    if (busy !== 1'b0 || jump_start !== 1'b1) begin
      bad++; $display("FAIL held_trig got busy=%0b js=%0b exp 0 1", busy, jump_start);
    end
    trigger = 1'b0;
    step();
    trigger = 1'b1;
    step();
    total++;
    if (busy !== 1'b1) begin
      bad++; $display("FAIL retrigger got busy=%0b exp 1", busy);
    end
    repeat (10) tick_once();
    #2;
    rst = 1'b1;
    #1;
    total++;
    if ({lights, busy, done, jump_start, rt_valid, reaction_time} !== 28'd0) begin
      bad++; $display("FAIL async_reset got l=%0h busy=%0b done=%0b js=%0b rv=%0b rt=%0d exp all 0",
                      lights, busy, done, jump_start, rt_valid, reaction_time);
    end
    repeat (2) step();
    #3;
    rst = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (done !== 1'b0 || busy !== 1'b0) done_seen++;
    end
    total++;
    if (done_seen !== 0) begin
      bad++; $display("FAIL reset_release got %0d cycles busy/done exp 0", done_seen);
    end
    trigger = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_full_run();
    test_jump_start();
    test_delay_bounds(4'd0, 1);
    test_delay_bounds(4'd15, 16);
    test_react_with_tick();
    test_saturation();
    test_trigger_held_and_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/f1_start_ctrl.md
Name: f1_start_ctrl

Overview:
Sequencer for an F1-style start-light sequence. On a start request it lights N_LIGHTS lamps one per tick, then holds all lamps lit for a random delay drawn from the external 4-bit LFSR, then extinguishes them and measures the reaction time to a button press. It owns the LFSR enable: the LFSR free-runs while the block waits and is frozen once the delay is sampled. It sits at top level beside the lfsr and clktick instances and drives the lamp bar.

Parameters:
N_LIGHTS, 8, number of lamps; N_LIGHTS >= 2
DELAY_MIN, 1, ticks added to the LFSR value to form the hold delay; must be >= 1
RT_WIDTH, 16, width of the reaction-time counter and output

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
tick  in  1  one-clk strobe, timebase for lamp steps, hold delay and reaction count
trigger  in  1  start request; rising edge detected internally
react  in  1  driver button; rising edge detected internally
lfsr_data  in  4  current LFSR value
lfsr_en  out  1  enable to the LFSR
lights  out  N_LIGHTS  lamp bar; bit 0 lights first
busy  out  1  high in any state other than IDLE
done  out  1  one-clk pulse at the end of a run (valid reaction or jump start)
jump_start  out  1  set when react comes before lamps-out; held until the next start
rt_valid  out  1  reaction_time is valid; held until the next start
reaction_time  out  RT_WIDTH  ticks from lamps-out to react edge, saturating

Behaviour:
- Reset (async): state=IDLE; lights=0; done=0; jump_start=0; rt_valid=0; reaction_time=0; internal counters=0.
- Edge detectors: trig_e = trigger & ~trigger_q, react_e = react & ~react_q. The _q registers reset to 1, so a level held high through reset is not an edge.
- lfsr_en = 1 in IDLE and LIGHTS, 0 in HOLD and REACT. This is combinational from the state.
- IDLE:
  - react_e is ignored.
  - trig_e goes to LIGHTS and clears light_cnt, jump_start, rt_valid and reaction_time.
- LIGHTS:
  - Each tick does lights <= {lights[N_LIGHTS-2:0],1'b1} and light_cnt++.
  - On the tick that makes lights all ones, go to HOLD.
  - In that same cycle, load delay_cnt = lfsr_data + DELAY_MIN. Use a 5-bit add with no overflow, giving a range of DELAY_MIN to 15+DELAY_MIN.
- HOLD:
  - Each tick decrements delay_cnt.
  - On the tick where delay_cnt==1, set lights<=0 and rt_cnt<=0, then go to REACT.
  - Lamps-out therefore comes exactly delay_cnt ticks after the last lamp lit.
- REACT:
  - Each tick does rt_cnt++, saturating at 2^RT_WIDTH-1.
  - On react_e: reaction_time<=rt_cnt, rt_valid<=1, done pulse, go to IDLE.
  - If react_e and tick fall in the same cycle, the value captured is the count before the increment.
- Jump start: react_e in LIGHTS or HOLD gives lights<=0, jump_start<=1, done pulse, go to IDLE. It has priority over a tick in the same cycle. rt_valid stays 0.
- trig_e outside IDLE is ignored.
- A tick arriving in the same cycle as the IDLE->LIGHTS transition is not counted; the first lamp lights on the next tick.
- done is registered and high for exactly one clk, in the cycle after the terminating event.
- An async reset mid-run aborts immediately to the reset values; no done pulse is generated.

Decomposition:
- Package f1_pkg holds:
  - state_t enum: IDLE, LIGHTS, HOLD, REACT (2 bits);
  - localparam LFSR_W=4;
  - localparam DELAY_W=5.
- Sub-module rise_detect (1-bit rising-edge detector, q reset to 1) is instantiated twice, for trigger and react.
- The LFSR stays a separate instance in the top level; this block only drives its enable.

Test Plan:
- Conditions for all cases unless stated: N_LIGHTS=8, DELAY_MIN=1, tick every 4 clk.
- Full run with lfsr_data=5 at capture: lights steps 0x01,0x03,…,0xFF on 8 ticks; lights go to 0x00 after 6 more ticks; react 3 ticks later gives reaction_time=3, rt_valid=1, one done pulse, busy=0.
- Jump start: react edge while lights=0x07 gives lights=0x00, jump_start=1, rt_valid=0, done pulse, state IDLE. A second react edge in IDLE gives no change.
- Delay bounds: lfsr_data=0 gives 1 hold tick; lfsr_data=15 gives 16 hold ticks. lfsr_en=0 throughout HOLD/REACT, so lfsr_data stays frozen.
- Boundary events:
  - react_e in the same clk as a tick in REACT with rt_cnt=4 gives reaction_time=4.
  - rt_cnt with RT_WIDTH=4 saturates at 15.
  - trigger held high after done gives no restart until it falls and rises again.
- Reset: assert rst mid-HOLD gives all outputs 0 asynchronously, with no done pulse. trigger held high across reset release gives no start.
